// File: rtl/display_timing_gen.sv
// display_timing_gen: 640x480@60 VGA raster timing from the system clock.
// Ports: clk, reset (sync, active-high) in; pix_tick, horz[9:0], vert[9:0],
//   video_on, horiz_sync, vert_sync, frame_start out.
// Option: define DTG_SYNC_DELAY_EN to delay video_on/syncs by one pixel.
module display_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   CLK_DIV  = 4,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] horz,
  output logic [9:0] vert,
  output logic       video_on,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       frame_start
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);

  localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          vo_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          fs_nxt;
  logic          vo_q;
  logic          hs_q;
  logic          vs_q;

  assign pix_tick = (div_cnt == DIV_MAX);

  always_comb begin
    h_nxt = horz;
    v_nxt = vert;
    if (pix_tick) begin
      if (horz == H_LAST) begin
        h_nxt = '0;
        if (vert == V_LAST) v_nxt = '0;
        else v_nxt = vert + 10'd1;
      end else begin
        h_nxt = horz + 10'd1;
      end
    end
  end

  // Decode from the next position so the registered flags line up
  // with horz/vert on the same edge.
  assign vo_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  assign hs_nxt = (h_nxt >= HS_BEG && h_nxt < HS_END) ?
                  SYNC_POL : ~SYNC_POL;
  assign vs_nxt = (v_nxt >= VS_BEG && v_nxt < VS_END) ?
                  SYNC_POL : ~SYNC_POL;
  assign fs_nxt = pix_tick && (h_nxt == '0) && (v_nxt == '0);

  // Reset parks the raster at the last blanking pixel so the first
  // tick lands on (0,0) and the first frame is whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      horz        <= H_LAST;
      vert        <= V_LAST;
      vo_q        <= 1'b0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= pix_tick ? '0 : div_cnt + DW'(1);
      horz        <= h_nxt;
      vert        <= v_nxt;
      vo_q        <= vo_nxt;
      hs_q        <= hs_nxt;
      vs_q        <= vs_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef DTG_SYNC_DELAY_EN
  logic vo_d;
  logic hs_d;
  logic vs_d;

  // One-pixel lag to match a colorizer that registers on pix_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      vo_d <= 1'b0;
      hs_d <= ~SYNC_POL;
      vs_d <= ~SYNC_POL;
    end else if (pix_tick) begin
      vo_d <= vo_q;
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign video_on   = vo_d;
  assign horiz_sync = hs_d;
  assign vert_sync  = vs_d;
`else
  assign video_on   = vo_q;
  assign horiz_sync = hs_q;
  assign vert_sync  = vs_q;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a default VGA instance plus a small
// raster instance (inverted sync polarity) so whole frames fit in a short run.
module tb_display_timing_gen;

`ifdef DTG_SYNC_DELAY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  localparam int CD = 4;
  localparam int HA [2] = '{640, 16};
  localparam int HF [2] = '{16, 2};
  localparam int HS [2] = '{96, 4};
  localparam int HB [2] = '{48, 3};
  localparam int VA [2] = '{480, 4};
  localparam int VF [2] = '{10, 1};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 2};
  localparam logic POL [2] = '{1'b0, 1'b1};

  typedef struct packed {
    logic       pt;
    logic [9:0] h;
    logic [9:0] v;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  typedef struct packed {
    int   d;
    int   h;
    int   v;
    logic vo;
    logic hs;
    logic vs;
    logic fs;
    logic dvo;
    logic dhs;
    logic dvs;
  } mst_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_pt, a_vo, a_hs, a_vs, a_fs;
  logic [9:0] a_h, a_v;
  logic       b_pt, b_vo, b_hs, b_vs, b_fs;
  logic [9:0] b_h, b_v;

  int checks = 0;
  int errors = 0;

  obs_t qa [$];
  obs_t qb [$];
  mst_t sa;
  mst_t sb;

  always #5 clk = ~clk;

  display_timing_gen u_a (
    .clk(clk), .reset(reset), .pix_tick(a_pt),
    .horz(a_h), .vert(a_v), .video_on(a_vo),
    .horiz_sync(a_hs), .vert_sync(a_vs), .frame_start(a_fs)
  );

  display_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(CD), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .reset(reset), .pix_tick(b_pt),
    .horz(b_h), .vert(b_v), .video_on(b_vo),
    .horiz_sync(b_hs), .vert_sync(b_vs), .frame_start(b_fs)
  );

  function automatic mst_t nxt(input int i, input mst_t s,
                               input logic rst);
    mst_t n;
    int ht;
    int vt;
    n  = s;
    ht = HA[i] + HF[i] + HS[i] + HB[i];
    vt = VA[i] + VF[i] + VS[i] + VB[i];
    if (rst) begin
      n.d = 0; n.h = ht - 1; n.v = vt - 1;
      n.vo = 1'b0; n.hs = !POL[i]; n.vs = !POL[i]; n.fs = 1'b0;
      n.dvo = 1'b0; n.dhs = !POL[i]; n.dvs = !POL[i];
    end else if (s.d == CD - 1) begin
      n.d = 0;
      n.dvo = s.vo; n.dhs = s.hs; n.dvs = s.vs;
      if (s.h == ht - 1) begin
        n.h = 0;
        n.v = (s.v == vt - 1) ? 0 : s.v + 1;
      end else begin
        n.h = s.h + 1;
      end
      n.vo = (n.h < HA[i]) && (n.v < VA[i]);
      n.hs = (n.h >= HA[i] + HF[i] && n.h < HA[i] + HF[i] + HS[i]) ?
             POL[i] : !POL[i];
      n.vs = (n.v >= VA[i] + VF[i] && n.v < VA[i] + VF[i] + VS[i]) ?
             POL[i] : !POL[i];
      n.fs = (n.h == 0) && (n.v == 0);
    end else begin
      n.d = s.d + 1;
      n.fs = 1'b0;
    end
    return n;
  endfunction

  function automatic obs_t obs(input mst_t s);
    obs_t o;
    o.pt = (s.d == CD - 1);
    o.h  = 10'(s.h);
    o.v  = 10'(s.v);
    o.vo = (LAG != 0) ? s.dvo : s.vo;
    o.hs = (LAG != 0) ? s.dhs : s.hs;
    o.vs = (LAG != 0) ? s.dvs : s.vs;
    o.fs = s.fs;
    return o;
  endfunction

  // Reference model: expected outputs queued at each active edge.
  always @(posedge clk) begin
    sa <= nxt(0, sa, reset);
    sb <= nxt(1, sb, reset);
    qa.push_back(obs(nxt(0, sa, reset)));
    qb.push_back(obs(nxt(1, sb, reset)));
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic sb_pop(input string tag, input obs_t o, ref obs_t q [$]);
    obs_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, o);
    end else begin
      e = q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_pop("sb_a", {a_pt, a_h, a_v, a_vo, a_hs, a_vs, a_fs}, qa);
    sb_pop("sb_b", {b_pt, b_h, b_v, b_vo, b_hs, b_vs, b_fs}, qb);
  endtask

  int n;
  int cyc;
  int hs_lo;
  int vs_act;
  int vo_fall;
  int hs_fall;
  int maxv;
  logic [9:0] prev;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_pix_tick", 32'(a_pt), 32'd0);
    end
    chk("rst_horz", 32'(a_h), 32'd799);
    chk("rst_vert", 32'(a_v), 32'd524);
    chk("rst_video_on", 32'(a_vo), 32'd0);
    chk("rst_hsync", 32'(a_hs), 32'd1);
    chk("rst_vsync", 32'(a_vs), 32'd1);
    chk("rst_frame_start", 32'(a_fs), 32'd0);
    chk("rst_b_hsync", 32'(b_hs), 32'd0);

    reset = 1'b0;
    n = 0;
    while (a_pt !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("first_tick_clk", 32'(n), 32'd3);
    tick();
    chk("start_horz", 32'(a_h), 32'd0);
    chk("start_vert", 32'(a_v), 32'd0);
    chk("start_video_on", 32'(a_vo), (LAG != 0) ? 32'd0 : 32'd1);
    chk("start_frame_start", 32'(a_fs), 32'd1);

    cyc = 0; hs_lo = 0; vo_fall = -1; hs_fall = -1; prev = a_h;
    do begin
      tick();
      cyc++;
      if (cyc == 1) chk("fs_one_clk", 32'(a_fs), 32'd0);
      if (a_hs === 1'b0) hs_lo++;
      if (vo_fall < 0 && a_vo === 1'b0) vo_fall = int'(a_h);
      if (hs_fall < 0 && a_hs === 1'b0) hs_fall = int'(a_h);
      if (a_h == 10'd0 && prev != 10'd0) break;
      prev = a_h;
    end while (cyc < 5000);
    chk("line_period", 32'(cyc), 32'd3200);
    chk("line_vert_inc", 32'(a_v), 32'd1);
    chk("hsync_clks", 32'(hs_lo), 32'(96 * CD));
    chk("video_off_horz", 32'(vo_fall), 32'(640 + LAG));
    chk("hsync_fall_horz", 32'(hs_fall), 32'(656 + LAG));

    n = 0;
    while (b_fs !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("b_fs_found", 32'(b_fs), 32'd1);
    for (int f = 0; f < 2; f++) begin
      cyc = 0; vs_act = 0; maxv = 0;
      do begin
        tick();
        cyc++;
        if (b_vs === 1'b1) vs_act++;
        if (int'(b_v) > maxv) maxv = int'(b_v);
      end while (b_fs !== 1'b1 && cyc < 2000);
      chk("b_frame_period", 32'(cyc), 32'd900);
      chk("b_vsync_clks", 32'(vs_act), 32'(2 * 25 * CD));
      chk("b_max_vert", 32'(maxv), 32'd8);
      chk("b_wrap_vert", 32'(b_v), 32'd0);
    end

    n = 0;
    while (!(a_h == 10'd300 && a_pt === 1'b1) && n < 4000) begin
      tick();
      n++;
    end
    chk("mid_pos_found", 32'(a_h), 32'd300);
    reset = 1'b1;
    tick();
    chk("mid_rst_horz", 32'(a_h), 32'd799);
    chk("mid_rst_vert", 32'(a_v), 32'd524);
    chk("mid_rst_video_on", 32'(a_vo), 32'd0);
    chk("mid_rst_fs", 32'(a_fs), 32'd0);
    chk("mid_rst_hsync", 32'(a_hs), 32'd1);
    chk("mid_rst_pix_tick", 32'(a_pt), 32'd0);
    reset = 1'b0;
    n = 0;
    while (a_pt !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("rec_tick_clk", 32'(n), 32'd3);
    tick();
    chk("rec_horz", 32'(a_h), 32'd0);
    chk("rec_vert", 32'(a_v), 32'd0);
    chk("rec_frame_start", 32'(a_fs), 32'd1);
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
